// File: rtl/rx_frame_checker.sv
// UART Rx frame checker: latches the deserialized word, samples parity and stop bits
// mid-bit, and queues {data, parity_err, frame_err} in a small FWFT FIFO with overrun flag.
module rx_frame_checker #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int CLKS_PER_BIT     = 16,
  parameter bit PARITY_ODD       = 1'b0,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_in_synced,
  input  logic                          data_is_valid,
  input  logic                          is_parity_stage,
  input  logic [INPUT_DATA_WIDTH-1:0]   received_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [INPUT_DATA_WIDTH-1:0]   rx_data,
  output logic                          rx_parity_error,
  output logic                          rx_frame_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun_error,
  input  logic                          overrun_clear
);

  localparam int CW = $clog2(2*CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = INPUT_DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, WAIT_PARITY, SAMPLE_PARITY, SAMPLE_STOP} state_t;

  state_t                      state, state_nxt;
  logic [CW-1:0]               cnt, cnt_nxt;
  logic [INPUT_DATA_WIDTH-1:0] hold, hold_nxt;
  logic                        pbit, pbit_nxt;
  logic                        dv_q, ps_q;
  logic                        dv_rise, ps_rise;
  logic                        push;
  logic [EW-1:0]               push_entry;

  assign dv_rise = data_is_valid & ~dv_q;
  assign ps_rise = is_parity_stage & ~ps_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hold  <= '0;
      pbit  <= 1'b0;
      dv_q  <= 1'b0;
      ps_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      hold  <= hold_nxt;
      pbit  <= pbit_nxt;
      dv_q  <= data_is_valid;
      ps_q  <= is_parity_stage;
    end
  end

  // Aborted and timed-out frames share the default entry: parity unknown, framing bad.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hold_nxt   = hold;
    pbit_nxt   = pbit;
    push       = 1'b0;
    push_entry = {hold, 1'b0, 1'b1};
    if (dv_rise) begin
      push      = (state != IDLE);
      hold_nxt  = received_data;
      cnt_nxt   = '0;
      state_nxt = WAIT_PARITY;
    end else begin
      case (state)
        WAIT_PARITY: begin
          if (ps_rise) begin
            cnt_nxt   = '0;
            state_nxt = SAMPLE_PARITY;
          end else if (cnt == CW'(2*CLKS_PER_BIT-1)) begin
            push      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        SAMPLE_PARITY: begin
          if (cnt == CW'(CLKS_PER_BIT/2-1)) begin
            pbit_nxt  = serial_in_synced;
            cnt_nxt   = '0;
            state_nxt = SAMPLE_STOP;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        SAMPLE_STOP: begin
          if (cnt == CW'(CLKS_PER_BIT-1)) begin
            push       = 1'b1;
            push_entry = {hold, (^{hold, pbit}) ^ PARITY_ODD, ~serial_in_synced};
            cnt_nxt    = '0;
            state_nxt  = IDLE;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          full, pop, wr;

  assign full = (count == (AW+1)'(FIFO_DEPTH));
  assign pop  = rx_valid & rx_ready;
  // When full, a simultaneous pop frees the slot the push lands in (wptr == rptr).
  assign wr   = push & (~full | pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      overrun_error <= 1'b0;
    end else begin
      if (wr) begin
        mem[wptr] <= push_entry;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push & full & ~pop) overrun_error <= 1'b1;
      else if (overrun_clear) overrun_error <= 1'b0;
    end
  end

  assign rx_valid   = (count != '0);
  assign fifo_count = count;
  assign {rx_data, rx_parity_error, rx_frame_error} = mem[rptr];

endmodule

// File: tb/tb_rx_frame_checker.sv
// Self-checking bench for rx_frame_checker: transaction-level model (scheduled pushes into
// a queue FIFO) compared every cycle, plus directed literal checks and random frames.
module tb_rx_frame_checker;
  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in_synced, data_is_valid, is_parity_stage;
  logic [7:0] received_data;
  logic       rx_ready, overrun_clear;
  logic       rx_valid_e, perr_e, ferr_e, ov_e;
  logic       rx_valid_o, perr_o, ferr_o, ov_o;
  logic [7:0] rx_data_e, rx_data_o;
  logic [2:0] cnt_e, cnt_o;

  always #5 clk = ~clk;

  rx_frame_checker #(.INPUT_DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut_even (
    .clk(clk), .reset(reset), .serial_in_synced(serial_in_synced), .data_is_valid(data_is_valid),
    .is_parity_stage(is_parity_stage), .received_data(received_data), .rx_valid(rx_valid_e),
    .rx_ready(rx_ready), .rx_data(rx_data_e), .rx_parity_error(perr_e), .rx_frame_error(ferr_e),
    .fifo_count(cnt_e), .overrun_error(ov_e), .overrun_clear(overrun_clear));

  rx_frame_checker #(.INPUT_DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(1), .FIFO_DEPTH(DEPTH)) dut_odd (
    .clk(clk), .reset(reset), .serial_in_synced(serial_in_synced), .data_is_valid(data_is_valid),
    .is_parity_stage(is_parity_stage), .received_data(received_data), .rx_valid(rx_valid_o),
    .rx_ready(rx_ready), .rx_data(rx_data_o), .rx_parity_error(perr_o), .rx_frame_error(ferr_o),
    .fifo_count(cnt_o), .overrun_error(ov_o), .overrun_clear(overrun_clear));

  typedef struct {
    int         at;
    logic [7:0] d;
    logic       pe, po, fe;
  } ent_t;

  ent_t        sched[$];
  ent_t        mq[$];
  logic [10:0] got[$];
  int          errors = 0, checks = 0;
  int          edge_n = 0;
  bit          ov = 1'b0;
  int          rdy_mode = 1, rdy_pct = 50, last_push_at = -1;
  bit          clr_force = 1'b0;

  // Parity error as defined on the serial frame: ones in data+parity must be even (or odd).
  function automatic logic par_err(logic [7:0] d, logic p, bit odd);
    return (($countones({d, p}) % 2) != 0) ^ odd;
  endfunction

  // Model: at each edge, pop if head valid & ready, then apply any push scheduled for this edge.
  bit   m_pop, m_hit, m_drop;
  ent_t m_e;
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (reset === 1'b1) begin
      m_pop = (mq.size() != 0) && rx_ready;
      m_hit = (sched.size() != 0) && (sched[0].at == edge_n);
      if (m_hit) m_e = sched.pop_front();
      if (m_pop) void'(mq.pop_front());
      m_drop = m_hit && (mq.size() >= DEPTH);
      if (m_hit && !m_drop) mq.push_back(m_e);
      if (m_drop) ov = 1'b1;
      else if (overrun_clear) ov = 1'b0;
    end
  end

  ent_t h;
  bit   exp_v, ok;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      exp_v = (mq.size() != 0);
      if (exp_v) h = mq[0];
      else begin h.at = 0; h.d = '0; h.pe = 0; h.po = 0; h.fe = 0; end
      ok = (rx_valid_e == exp_v) && (rx_valid_o == exp_v) && (cnt_e == mq.size()) &&
           (cnt_o == mq.size()) && (ov_e == ov) && (ov_o == ov);
      if (exp_v)
        ok = ok && (rx_data_e == h.d) && (perr_e == h.pe) && (ferr_e == h.fe) &&
             (rx_data_o == h.d) && (perr_o == h.po) && (ferr_o == h.fe);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL cycle_cmp edge=%0d got v=%0b cnt=%0d ov=%0b d=%h pe=%b fe=%b odd(v=%0b cnt=%0d pe=%b) exp v=%0b cnt=%0d ov=%0b d=%h pe=%b odd_pe=%b fe=%b",
                 edge_n, rx_valid_e, cnt_e, ov_e, rx_data_e, perr_e, ferr_e, rx_valid_o, cnt_o, perr_o,
                 exp_v, mq.size(), ov, h.d, h.pe, h.po, h.fe);
      end
      if (rx_valid_e && rx_ready) got.push_back({rx_data_e, perr_e, perr_o, ferr_e});
    end
  end

  // Consumer-side driver runs at #2 so mode changes made at #1 by the stimulus apply that cycle.
  initial begin
    rx_ready = 1'b0;
    overrun_clear = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0:       rx_ready = ($urandom_range(0, 99) < rdy_pct);
        1:       rx_ready = 1'b0;
        2:       rx_ready = 1'b1;
        default: rx_ready = (edge_n + 1 == last_push_at);
      endcase
      overrun_clear = clr_force || (rdy_mode == 0 && $urandom_range(0, 31) == 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, req);
    end
  endtask

  task automatic chk_got(string name, int idx, logic [10:0] req);
    if (got.size() <= idx) chk({name, "_missing"}, got.size(), idx + 1);
    else chk(name, {21'b0, got[idx]}, {21'b0, req});
  endtask

  // Full frame: rise of data_is_valid, w extra cycles, parity bit, stop bit.
  task automatic send_frame(logic [7:0] d, logic pb, logic stop, int w);
    ent_t e;
    received_data = d;
    data_is_valid = 1'b1;
    tick();
    repeat (w) tick();
    is_parity_stage  = 1'b1;
    serial_in_synced = pb;
    data_is_valid    = 1'b0;
    e.at = edge_n + 1 + CPB/2 + CPB;
    e.d  = d;
    e.pe = par_err(d, pb, 0);
    e.po = par_err(d, pb, 1);
    e.fe = ~stop;
    sched.push_back(e);
    last_push_at = e.at;
    repeat (CPB) tick();
    is_parity_stage  = 1'b0;
    serial_in_synced = stop;
    repeat (CPB) tick();
    serial_in_synced = 1'b1;
  endtask

  task automatic timeout_frame(logic [7:0] d);
    ent_t e;
    e.at = edge_n + 1 + 2*CPB;
    e.d = d; e.pe = 0; e.po = 0; e.fe = 1;
    sched.push_back(e);
    received_data = d;
    data_is_valid = 1'b1;
    tick(); tick();
    data_is_valid = 1'b0;
    repeat (2*CPB + 1) tick();
  endtask

  // First frame is cut off by a new word j cycles into its stop bit; second frame completes.
  task automatic abort_frame(logic [7:0] d1, logic [7:0] d2, int j, logic pb2, logic stop2);
    ent_t e;
    received_data = d1;
    data_is_valid = 1'b1;
    tick();
    is_parity_stage  = 1'b1;
    serial_in_synced = 1'b0;
    data_is_valid    = 1'b0;
    repeat (CPB) tick();
    is_parity_stage  = 1'b0;
    serial_in_synced = 1'b1;
    repeat (j) tick();
    e.at = edge_n + 1;
    e.d = d1; e.pe = 0; e.po = 0; e.fe = 1;
    sched.push_back(e);
    send_frame(d2, pb2, stop2, 1);
  endtask

  task automatic model_reset();
    mq.delete();
    sched.delete();
    ov = 1'b0;
  endtask

  logic [7:0] rd, rd2;
  int         kind;

  initial begin
    reset = 1'b0;
    serial_in_synced = 1'b1;
    data_is_valid = 1'b0;
    is_parity_stage = 1'b0;
    received_data = '0;
    repeat (3) tick();
    chk("rst_valid", rx_valid_e, 0);
    chk("rst_data", rx_data_e, 0);
    chk("rst_errs", {perr_e, ferr_e}, 0);
    chk("rst_count", cnt_e, 0);
    chk("rst_overrun", ov_e, 0);
    reset = 1'b1;
    tick();

    // Clean frame, then parity and framing faults on the same word.
    rdy_mode = 2;
    got.delete();
    send_frame(8'hA5, 1'b0, 1'b1, 2);
    chk("t1_count", got.size(), 1);
    chk_got("t1_a5", 0, {8'hA5, 1'b0, 1'b1, 1'b0});
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    chk_got("t2_perr", 1, {8'hA5, 1'b1, 1'b0, 1'b0});
    send_frame(8'hA5, 1'b0, 1'b0, 3);
    chk_got("t2_ferr", 2, {8'hA5, 1'b0, 1'b1, 1'b1});

    // Stalled consumer: fifth frame overruns.
    rdy_mode = 1;
    got.delete();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), ^8'(i), 1'b1, 1);
    chk("t3_count_full", cnt_e, 4);
    chk("t3_overrun_set", ov_e, 1);
    rdy_mode = 2;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) chk_got("t3_drain", i, {8'(i + 1), 1'b0, 1'b1, 1'b0});
    chk("t3_drain_n", got.size(), 4);
    clr_force = 1'b1;
    tick();
    clr_force = 1'b0;
    tick();
    chk("t3_overrun_clr", ov_e, 0);

    // Full FIFO, pop on the exact push edge.
    rdy_mode = 1;
    got.delete();
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), ^(8'h11 + 8'(i)), 1'b1, 0);
    rdy_mode = 3;
    send_frame(8'h15, ^8'h15, 1'b1, 2);
    chk("t4_count", cnt_e, 4);
    chk("t4_no_overrun", ov_e, 0);
    rdy_mode = 2;
    repeat (6) tick();
    for (int i = 0; i < 5; i++) chk_got("t4_order", i, {8'h11 + 8'(i), 1'b0, 1'b1, 1'b0});

    // Parity-stage timeout, then abort in the stop bit.
    got.delete();
    timeout_frame(8'h5A);
    abort_frame(8'h66, 8'h99, 4, 1'b0, 1'b1);
    repeat (2) tick();
    chk_got("t5_timeout", 0, {8'h5A, 1'b0, 1'b0, 1'b1});
    chk_got("t5_aborted", 1, {8'h66, 1'b0, 1'b0, 1'b1});
    chk_got("t5_second", 2, {8'h99, 1'b0, 1'b1, 1'b0});

    // Async reset mid-frame with two entries queued.
    rdy_mode = 1;
    send_frame(8'h21, ^8'h21, 1'b1, 0);
    send_frame(8'h22, ^8'h22, 1'b1, 0);
    chk("t6_queued", cnt_e, 2);
    received_data = 8'h77;
    data_is_valid = 1'b1;
    tick(); tick();
    is_parity_stage = 1'b1;
    serial_in_synced = 1'b0;
    data_is_valid = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_valid", rx_valid_e, 0);
    chk("t6_rst_count", cnt_e, 0);
    tick();
    is_parity_stage = 1'b0;
    serial_in_synced = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    rdy_mode = 2;
    got.delete();
    send_frame(8'h3C, 1'b0, 1'b1, 1);
    repeat (2) tick();
    chk_got("t6_after_reset", 0, {8'h3C, 1'b0, 1'b1, 1'b0});

    // Randomized traffic with varying consumer throughput.
    rdy_mode = 0;
    for (int i = 0; i < 120; i++) begin
      if (i % 10 == 0) begin
        case ($urandom_range(0, 4))
          0: rdy_pct = 0;
          1: rdy_pct = 2;
          2: rdy_pct = 10;
          3: rdy_pct = 50;
          default: rdy_pct = 100;
        endcase
      end
      kind = $urandom_range(0, 9);
      rd   = 8'($urandom);
      rd2  = 8'($urandom);
      if (kind == 0) timeout_frame(rd);
      else if (kind == 1) abort_frame(rd, rd2, $urandom_range(1, 7), 1'($urandom), ($urandom_range(0, 4) != 0));
      else send_frame(rd, (^rd) ^ ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0), $urandom_range(0, 4));
      repeat ($urandom_range(0, 3)) tick();
    end
    rdy_mode = 2;
    repeat (10) tick();
    chk("final_empty", cnt_e, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

endmodule
